// File: rtl/gpio_evt_pkg.sv
// Shared definitions for the GPIO input event controller: detect modes,
// event-port FSM states and the pin-index width helper.
package gpio_evt_pkg;

  localparam logic [1:0] EVT_RISE = 2'd0;
  localparam logic [1:0] EVT_FALL = 2'd1;
  localparam logic [1:0] EVT_BOTH = 2'd2;
  localparam logic [1:0] EVT_LVLH = 2'd3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } evt_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_in_event_ctrl_sync_edge.sv
// Per-pin synchroniser, previous-sample register and edge/level detector.
// Detection is gated by the pin enable and by the top-level prime flag.
module gpio_sync_edge
  import gpio_evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pad,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_primed,
  output logic       o_detect
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;
  logic                   w_raw;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      r_prev <= w_s;
    end
  end

  always_comb begin
    w_raw = 1'b0;
    case (i_mode)
      EVT_RISE: w_raw = w_s & ~r_prev;
      EVT_FALL: w_raw = ~w_s & r_prev;
      EVT_BOTH: w_raw = w_s ^ r_prev;
      EVT_LVLH: w_raw = w_s;
      default:  w_raw = 1'b0;
    endcase
  end

  assign o_detect = w_raw & i_en & i_primed;

endmodule

// File: rtl/gpio_in_event_ctrl.sv
// GPIO input event controller: sticky W1C status, registered IRQ and a
// valid/ready event port that serialises per-pin events lowest index first.
module gpio_in_event_ctrl
  import gpio_evt_pkg::*;
#(
  parameter  int NUM_PINS    = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int PIN_IDX_W   = idx_width(NUM_PINS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_PINS-1:0]   i_pad_in,
  input  logic [NUM_PINS-1:0]   i_int_en,
  input  logic [2*NUM_PINS-1:0] i_int_type,
  input  logic [NUM_PINS-1:0]   i_irq_mask,
  input  logic [NUM_PINS-1:0]   i_status_clr,
  input  logic                  i_ovf_clr,
  output logic [NUM_PINS-1:0]   o_int_status,
  output logic                  o_irq,
  output logic                  o_evt_valid,
  output logic [PIN_IDX_W-1:0]  o_evt_pin,
  input  logic                  i_evt_ready,
  output logic                  o_evt_overflow,
  output evt_state_t            o_dbg_state
);

  // Event port handshake: an event transfers on a clock edge where
  // o_evt_valid and i_evt_ready are both high; o_evt_pin is held stable
  // while o_evt_valid is high and i_evt_ready is low.

  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [2:0]           r_prime;
  logic                 w_primed;
  logic [NUM_PINS-1:0]  w_det;
  logic [NUM_PINS-1:0]  r_status;
  logic [NUM_PINS-1:0]  r_pend;
  logic                 r_irq;
  logic                 r_ovf;
  logic [PIN_IDX_W-1:0] r_evt_pin;
  evt_state_t           r_state;
  evt_state_t           w_state_nxt;
  logic                 w_load;
  logic                 w_pend_any;
  logic [PIN_IDX_W-1:0] w_next_pin;
  logic [NUM_PINS-1:0]  w_load_mask;

  assign w_primed = (r_prime == PRIME_DONE);

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_pad    (i_pad_in[g]),
      .i_en     (i_int_en[g]),
      .i_mode   (i_int_type[2*g +: 2]),
      .i_primed (w_primed),
      .o_detect (w_det[g])
    );
  end

  assign w_pend_any = |r_pend;

  always_comb begin
    w_next_pin = '0;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (r_pend[i]) w_next_pin = PIN_IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend_any) begin
          w_load      = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (i_evt_ready) begin
          if (w_pend_any) w_load = 1'b1;
          else            w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load_mask = '0;
    if (w_load) w_load_mask[w_next_pin] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prime   <= '0;
      r_status  <= '0;
      r_pend    <= '0;
      r_irq     <= 1'b0;
      r_ovf     <= 1'b0;
      r_evt_pin <= '0;
      r_state   <= ST_IDLE;
    end else begin
      if (!w_primed) r_prime <= r_prime + 3'd1;
      // A fresh detect outranks a same-cycle clear or arbiter load.
      r_status <= w_det | (r_status & ~i_status_clr);
      r_pend   <= w_det | (r_pend & ~w_load_mask);
      r_irq    <= |(r_status & i_irq_mask);
      if (|(w_det & r_pend)) r_ovf <= 1'b1;
      else if (i_ovf_clr)    r_ovf <= 1'b0;
      if (w_load) r_evt_pin <= w_next_pin;
      r_state <= w_state_nxt;
    end
  end

  assign o_int_status   = r_status;
  assign o_irq          = r_irq;
  assign o_evt_valid    = (r_state == ST_PRESENT);
  assign o_evt_pin      = r_evt_pin;
  assign o_evt_overflow = r_ovf;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_gpio_in_event_ctrl.sv
// Scenario bench for gpio_in_event_ctrl with a cycle-level reference model
// driven from the pad history for the randomized run.
module tb_gpio_in_event_ctrl;
  import gpio_evt_pkg::*;

  localparam int NP  = 8;
  localparam int SS  = 2;
  localparam int PW  = 3;
  localparam int NR  = 600;
  localparam int OFF = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   pad, en, mask, sclr;
  logic [2*NP-1:0] typ;
  logic            ovf_clr, ready;
  logic [NP-1:0]   status;
  logic            irq, valid, ovf;
  logic [PW-1:0]   pin;
  evt_state_t      dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [PW-1:0] got_q[$];
  logic [PW-1:0] exp_q[$];
  int            got_cnt[NP] = '{default: 0};

  gpio_in_event_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(SS)) dut (
    .i_clk(clk), .i_rst(rst), .i_pad_in(pad), .i_int_en(en), .i_int_type(typ),
    .i_irq_mask(mask), .i_status_clr(sclr), .i_ovf_clr(ovf_clr),
    .o_int_status(status), .o_irq(irq), .o_evt_valid(valid), .o_evt_pin(pin),
    .i_evt_ready(ready), .o_evt_overflow(ovf), .o_dbg_state(dbg)
  );

  always #5 clk = ~clk;

  // Consumer monitor: records every accepted event.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      got_q.push_back(pin);
      got_cnt[pin] = got_cnt[pin] + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    sclr = '1; ovf_clr = 1'b1;
    step();
    sclr = '0; ovf_clr = 1'b0;
    step();
  endtask

  function automatic logic det_of(input logic [1:0] m, input logic cur, input logic old);
    case (m)
      2'd0:    return cur & ~old;
      2'd1:    return ~cur & old;
      2'd2:    return cur ^ old;
      default: return cur;
    endcase
  endfunction

  task automatic test_reset();
    logic bad;
    rst = 1'b1; pad = 8'h01; en = 8'h01; typ = '0; mask = 8'h01; ready = 1'b1;
    repeat (3) step();
    n_checks++; if ({status, irq, valid, ovf} !== 11'h0) $display("FAIL reset_outputs: got %h exp 0", {status, irq, valid, ovf}); else n_pass++;
    n_checks++; if (dbg !== ST_IDLE) $display("FAIL reset_state: got %0d exp %0d", dbg, ST_IDLE); else n_pass++;
    rst = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      step();
      if (status !== 8'h00 || irq !== 1'b0 || valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL prime_no_false_edge: got 1 exp 0"); else n_pass++;
    pad[0] = 1'b0;
    repeat (6) step();
    n_checks++; if (status !== 8'h00) $display("FAIL prime_fall_ignored: got %h exp 00", status); else n_pass++;
    pad[0] = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= SS; k++) begin
      step();
      if (status[0] !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL latency_early: status set before %0d cycles", SS + 1); else n_pass++;
    step();
    n_checks++; if (status[0] !== 1'b1) $display("FAIL latency_status: got %b exp 1", status[0]); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL latency_irq_early: got %b exp 0", irq); else n_pass++;
    step();
    n_checks++; if (irq !== 1'b1) $display("FAIL latency_irq: got %b exp 1", irq); else n_pass++;
    repeat (6) step();
    n_checks++; if (got_cnt[0] !== 1) $display("FAIL prime_event_count: got %0d exp 1", got_cnt[0]); else n_pass++;
    clear_all();
    n_checks++; if (status !== 8'h00) $display("FAIL prime_clear: got %h exp 00", status); else n_pass++;
  endtask

  task automatic test_modes();
    int b[4];
    en = 8'h0F; typ = {8'h00, EVT_LVLH, EVT_BOTH, EVT_FALL, EVT_RISE}; pad = '0; mask = '0; ready = 1'b1;
    repeat (6) step();
    clear_all();
    for (int p = 0; p < 4; p++) b[p] = got_cnt[p];
    for (int p = 0; p < 3; p++) begin
      pad[p] = 1'b1; repeat (5) step();
      pad[p] = 1'b0; repeat (12) step();
    end
    n_checks++; if (got_cnt[0] - b[0] !== 1) $display("FAIL mode_rise_count: got %0d exp 1", got_cnt[0] - b[0]); else n_pass++;
    n_checks++; if (got_cnt[1] - b[1] !== 1) $display("FAIL mode_fall_count: got %0d exp 1", got_cnt[1] - b[1]); else n_pass++;
    n_checks++; if (got_cnt[2] - b[2] !== 2) $display("FAIL mode_both_count: got %0d exp 2", got_cnt[2] - b[2]); else n_pass++;
    n_checks++; if (status !== 8'h07) $display("FAIL mode_status_edges: got %h exp 07", status); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL mode_edges_no_ovf: got %b exp 0", ovf); else n_pass++;
    pad[3] = 1'b1; repeat (5) step();
    pad[3] = 1'b0; repeat (12) step();
    n_checks++; if (status[3] !== 1'b1) $display("FAIL mode_level_status: got %b exp 1", status[3]); else n_pass++;
    n_checks++; if ((got_cnt[3] - b[3] >= 1) !== 1'b1) $display("FAIL mode_level_events: got %0d exp >=1", got_cnt[3] - b[3]); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL mode_level_ovf: got %b exp 1", ovf); else n_pass++;
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0; step();
    n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b exp 0", ovf); else n_pass++;
    clear_all();
  endtask

  task automatic test_arbitration();
    en = 8'hA4; typ = '0; pad = '0; ready = 1'b1; mask = '0;
    repeat (6) step();
    clear_all();
    exp_q = '{3'd2, 3'd5, 3'd7};
    pad = 8'hA4;
    repeat (SS + 1) step();
    n_checks++; if (valid !== 1'b0) $display("FAIL arb_not_early: got %b exp 0", valid); else n_pass++;
    while (exp_q.size() > 0) begin
      step();
      n_checks++; if ({valid, pin} !== {1'b1, exp_q[0]}) $display("FAIL arb_seq: got v=%b pin=%0d exp v=1 pin=%0d", valid, pin, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front());
    end
    step();
    n_checks++; if (valid !== 1'b0) $display("FAIL arb_drain: got %b exp 0", valid); else n_pass++;
    pad = '0;
    repeat (6) step();
    clear_all();
  endtask

  task automatic test_back_to_back();
    int  b;
    logic bad;
    en = 8'h08; typ = '0; pad = '0; ready = 1'b1; mask = '0;
    repeat (6) step();
    clear_all();
    ready = 1'b0; b = got_cnt[3]; bad = 1'b0;
    for (int e = 0; e < 2; e++) begin
      pad[3] = 1'b1;
      repeat (4) begin step(); if (e == 1 && (valid !== 1'b1 || pin !== 3'd3 || ovf !== 1'b0)) bad = 1'b1; end
      pad[3] = 1'b0;
      repeat (6) begin step(); if (valid !== 1'b1 || pin !== 3'd3 || ovf !== 1'b0) bad = 1'b1; end
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL bp_hold: pin/valid unstable or early ovf (v=%b pin=%0d ovf=%b)", valid, pin, ovf); else n_pass++;
    pad[3] = 1'b1; repeat (4) step();
    n_checks++; if (ovf !== 1'b1) $display("FAIL bp_ovf: got %b exp 1", ovf); else n_pass++;
    pad[3] = 1'b0; repeat (6) step();
    ready = 1'b1; repeat (10) step();
    n_checks++; if (got_cnt[3] - b !== 2) $display("FAIL bp_count: got %0d exp 2", got_cnt[3] - b); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL bp_idle: got %b exp 0", valid); else n_pass++;
    clear_all();
  endtask

  task automatic test_w1c();
    en = 8'h10; typ = '0; mask = 8'h10; pad = '0; ready = 1'b1;
    repeat (6) step();
    clear_all();
    step();
    pad[4] = 1'b1;
    repeat (SS) step();
    sclr = 8'h10;
    step();
    sclr = '0;
    n_checks++; if (status[4] !== 1'b1) $display("FAIL w1c_race: got %b exp 1", status[4]); else n_pass++;
    repeat (8) step();
    n_checks++; if (irq !== 1'b1) $display("FAIL w1c_irq_high: got %b exp 1", irq); else n_pass++;
    sclr = 8'h10; step(); sclr = '0;
    n_checks++; if (status[4] !== 1'b0) $display("FAIL w1c_clear: got %b exp 0", status[4]); else n_pass++;
    n_checks++; if (irq !== 1'b1) $display("FAIL w1c_irq_lag: got %b exp 1", irq); else n_pass++;
    step();
    n_checks++; if (irq !== 1'b0) $display("FAIL w1c_irq_fall: got %b exp 0", irq); else n_pass++;
    pad[4] = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset_mid();
    int  base;
    logic bad;
    en = 8'h4B; typ = '0; pad = '0; ready = 1'b0; mask = 8'hFF;
    repeat (6) step();
    clear_all();
    pad = 8'h4B;
    repeat (SS + 4) step();
    n_checks++; if ({valid, pin} !== {1'b1, 3'd0}) $display("FAIL rm_present: got v=%b pin=%0d exp v=1 pin=0", valid, pin); else n_pass++;
    rst = 1'b1; step();
    n_checks++; if ({valid, status, irq, ovf} !== 11'h0) $display("FAIL rm_reset: got %h exp 0", {valid, status, irq, ovf}); else n_pass++;
    rst = 1'b0; ready = 1'b1; base = got_q.size(); bad = 1'b0;
    repeat (20) begin step(); if (valid !== 1'b0) bad = 1'b1; end
    n_checks++; if (bad !== 1'b0 || got_q.size() !== base) $display("FAIL rm_no_stale: got %0d events exp 0", got_q.size() - base); else n_pass++;
    pad[1] = 1'b0; repeat (4) step();
    pad[1] = 1'b1; repeat (8) step();
    n_checks++; if (got_q.size() !== base + 1) $display("FAIL rm_fresh_count: got %0d exp 1", got_q.size() - base); else n_pass++;
    n_checks++; if (got_q[got_q.size() - 1] !== 3'd1) $display("FAIL rm_fresh_pin: got %0d exp 1", got_q[got_q.size() - 1]); else n_pass++;
    pad = '0; repeat (6) step();
    clear_all();
  endtask

  task automatic test_random();
    logic [NP-1:0] ph[NR + OFF];
    int            last[NP];
    int            exp_cnt[NP];
    int            b[NP];
    logic [NP-1:0] exp_st, det;
    logic          exp_irq;
    logic [1:0]    m;
    int            bad_st, bad_irq;
    en = '1; pad = '0; ready = 1'b1; mask = NP'($urandom);
    for (int p = 0; p < NP; p++) typ[2*p +: 2] = 2'($urandom_range(0, 2));
    repeat (10) step();
    clear_all();
    step();
    for (int i = 0; i < OFF; i++) ph[i] = '0;
    for (int p = 0; p < NP; p++) begin last[p] = -100; exp_cnt[p] = 0; b[p] = got_cnt[p]; end
    exp_st = '0; exp_irq = 1'b0; bad_st = 0; bad_irq = 0;
    for (int e = 0; e < NR; e++) begin
      if (status !== exp_st) begin bad_st++; if (bad_st < 4) $display("FAIL rnd_status @%0d: got %h exp %h", e, status, exp_st); end
      if (irq !== exp_irq) begin bad_irq++; if (bad_irq < 4) $display("FAIL rnd_irq @%0d: got %b exp %b", e, irq, exp_irq); end
      if (e < NR - 20) begin
        for (int p = 0; p < NP; p++) begin
          if (e - last[p] >= 12 && $urandom_range(0, 7) == 0) begin pad[p] = ~pad[p]; last[p] = e; end
        end
      end
      sclr = ($urandom_range(0, 15) == 0) ? NP'($urandom) : '0;
      ph[e + OFF] = pad;
      for (int p = 0; p < NP; p++) begin
        m = typ[2*p +: 2];
        det[p] = det_of(m, ph[e + OFF - SS][p], ph[e + OFF - SS - 1][p]);
        if (det[p]) exp_cnt[p]++;
      end
      exp_irq = |(exp_st & mask);
      exp_st  = det | (exp_st & ~sclr);
      step();
    end
    sclr = '0;
    n_checks++; if (bad_st !== 0) $display("FAIL rnd_status_total: got %0d bad cycles exp 0", bad_st); else n_pass++;
    n_checks++; if (bad_irq !== 0) $display("FAIL rnd_irq_total: got %0d bad cycles exp 0", bad_irq); else n_pass++;
    repeat (20) step();
    for (int p = 0; p < NP; p++) begin
      n_checks++; if (got_cnt[p] - b[p] !== exp_cnt[p]) $display("FAIL rnd_events pin%0d: got %0d exp %0d", p, got_cnt[p] - b[p], exp_cnt[p]); else n_pass++;
    end
    n_checks++; if (ovf !== 1'b0) $display("FAIL rnd_no_ovf: got %b exp 0", ovf); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; pad = '0; en = '0; typ = '0; mask = '0; sclr = '0; ovf_clr = 1'b0; ready = 1'b1;
    test_reset();
    test_modes();
    test_arbitration();
    test_back_to_back();
    test_w1c();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
